// File: rtl/parking_access_ctrl_if.sv
// Lane-side bundle of the parking gate controller: sensors and keypad in, gate/alarm/debug out.
// The keypad/sensor side drives through master; the controller attaches as slave.
interface parking_access_ctrl_if #(
   parameter int PIN_WIDTH = 16,
   parameter int ATT_W     = 2
);
   logic                 sensor_llegada_vehiculo;
   logic                 sensor_ingreso_vehiculo;
   logic                 pin_valid;
   logic [PIN_WIDTH-1:0] pin_data;
   logic                 senal_compuerta;
   logic                 senal_alarma_pin;
   logic                 senal_alarma_bloqueo;
   logic [2:0]           estado;
   logic [ATT_W-1:0]     cuenta_intentos;

   modport master (
      output sensor_llegada_vehiculo, sensor_ingreso_vehiculo, pin_valid, pin_data,
      input  senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, estado, cuenta_intentos
   );

   modport slave (
      input  sensor_llegada_vehiculo, sensor_ingreso_vehiculo, pin_valid, pin_data,
      output senal_compuerta, senal_alarma_pin, senal_alarma_bloqueo, estado, cuenta_intentos
   );
endinterface

// File: rtl/parking_access_ctrl.sv
// Single-lane parking gate controller: PIN entry with attempt limit, gate-open timeout,
// PIN lockout and tailgating block. Moore FSM with outputs registered alongside the state.
module parking_access_ctrl #(
   parameter int                   PIN_WIDTH    = 16,
   parameter logic [PIN_WIDTH-1:0] CORRECT_PIN  = 16'h2468,
   parameter int                   MAX_ATTEMPTS = 3,
   parameter int                   GATE_TIMEOUT = 1000
) (
   input logic                  clock,
   input logic                  reset,
   parking_access_ctrl_if.slave bus
);
   localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
   localparam int TMR_W = $clog2(GATE_TIMEOUT);
   localparam logic [ATT_W-1:0] ATT_LAST = ATT_W'(MAX_ATTEMPTS);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_PIN = 3'd1,
      OPEN     = 3'd2,
      PASSING  = 3'd3,
      PIN_LOCK = 3'd4,
      BLOCK    = 3'd5
   } state_t;

   state_t           state, nxt_state;
   logic [ATT_W-1:0] cnt, nxt_cnt, cnt_inc;
   logic [TMR_W-1:0] timer, nxt_timer;
   logic             compuerta, alarma_pin, alarma_bloqueo;
   logic             llegada, ingreso, both, pin_ok, pin_bad;

   assign llegada = bus.sensor_llegada_vehiculo;
   assign ingreso = bus.sensor_ingreso_vehiculo;
   assign both    = llegada & ingreso;
   assign pin_ok  = bus.pin_valid & (bus.pin_data == CORRECT_PIN);
   assign pin_bad = bus.pin_valid & (bus.pin_data != CORRECT_PIN);
   assign cnt_inc = cnt + 1'b1;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_timer = '0;
      if (both) begin
         nxt_state = BLOCK;
      end else begin
         case (state)
            IDLE:     if (llegada && !ingreso) nxt_state = WAIT_PIN;
            WAIT_PIN: begin
               // A strobe in the same cycle the vehicle leaves is still honoured.
               if (pin_ok)                   nxt_state = OPEN;
               else if (pin_bad) begin
                  if (cnt_inc == ATT_LAST)   nxt_state = PIN_LOCK;
                  else                       nxt_cnt   = cnt_inc;
               end
               else if (!llegada && !ingreso) nxt_state = IDLE;
            end
            OPEN: begin
               if (ingreso && !llegada)  nxt_state = PASSING;
               else if (timer == TMR_LAST) nxt_state = IDLE;
            end
            PASSING:  if (!ingreso) nxt_state = IDLE;
            PIN_LOCK: if (pin_ok)   nxt_state = IDLE;
            BLOCK:    if (pin_ok)   nxt_state = IDLE;
            default:  nxt_state = IDLE;
         endcase
      end
      // The attempt count only lives within a WAIT_PIN session.
      if (nxt_state != WAIT_PIN) nxt_cnt = '0;
      if (state == OPEN && nxt_state == OPEN && timer != TMR_LAST) nxt_timer = timer + 1'b1;
      else if (state == OPEN && nxt_state == OPEN)                 nxt_timer = timer;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         timer          <= '0;
         compuerta      <= 1'b0;
         alarma_pin     <= 1'b0;
         alarma_bloqueo <= 1'b0;
      end else begin
         state          <= nxt_state;
         cnt            <= nxt_cnt;
         timer          <= nxt_timer;
         compuerta      <= (nxt_state == OPEN) || (nxt_state == PASSING);
         alarma_pin     <= (nxt_state == PIN_LOCK);
         alarma_bloqueo <= (nxt_state == BLOCK);
      end
   end

   assign bus.senal_compuerta      = compuerta;
   assign bus.senal_alarma_pin     = alarma_pin;
   assign bus.senal_alarma_bloqueo = alarma_bloqueo;
   assign bus.estado               = state;
   assign bus.cuenta_intentos      = cnt;
endmodule

// File: tb/tb_parking_access_ctrl.sv
// Bench for parking_access_ctrl: directed scenarios then randomized traffic,
// all checked against a behavioural model of the gate rules.
module tb_parking_access_ctrl;
   localparam int              PIN_WIDTH    = 16;
   localparam logic [15:0]     CORRECT_PIN  = 16'h2468;
   localparam int              MAX_ATTEMPTS = 3;
   localparam int              GATE_TIMEOUT = 8;
   localparam int              ATT_W        = $clog2(MAX_ATTEMPTS + 1);
   localparam int S_IDLE = 0, S_WAIT = 1, S_OPEN = 2, S_PASS = 3, S_LOCK = 4, S_BLOCK = 5;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   parking_access_ctrl_if #(.PIN_WIDTH(PIN_WIDTH), .ATT_W(ATT_W)) bus ();

   parking_access_ctrl #(
      .PIN_WIDTH(PIN_WIDTH), .CORRECT_PIN(CORRECT_PIN),
      .MAX_ATTEMPTS(MAX_ATTEMPTS), .GATE_TIMEOUT(GATE_TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_err = 0;
   int m_st = S_IDLE;
   int m_cnt = 0;
   int m_open = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: gate rules applied to abstract state, attempts and time spent open.
   task automatic model(input bit rs, input bit l, input bit g, input bit pv, input logic [15:0] pd);
      bit ok, bad;
      int nst;
      ok  = pv && (pd == CORRECT_PIN);
      bad = pv && !ok;
      if (rs) begin
         m_st = S_IDLE; m_cnt = 0; m_open = 0;
         return;
      end
      nst = m_st;
      if (l && g) nst = S_BLOCK;
      else begin
         case (m_st)
            S_IDLE:  if (l && !g) nst = S_WAIT;
            S_WAIT: begin
               if (ok) nst = S_OPEN;
               else if (bad) begin
                  if (m_cnt + 1 >= MAX_ATTEMPTS) nst = S_LOCK;
                  else m_cnt = m_cnt + 1;
               end else if (!l && !g) nst = S_IDLE;
            end
            S_OPEN: begin
               if (g && !l) nst = S_PASS;
               else if (m_open >= GATE_TIMEOUT) nst = S_IDLE;
            end
            S_PASS:  if (!g) nst = S_IDLE;
            S_LOCK:  if (ok) nst = S_IDLE;
            S_BLOCK: if (ok) nst = S_IDLE;
            default: nst = S_IDLE;
         endcase
      end
      if (nst != S_WAIT) m_cnt = 0;
      if (nst == S_OPEN) m_open = (m_st == S_OPEN) ? m_open + 1 : 1;
      else m_open = 0;
      m_st = nst;
   endtask

   task automatic step(input bit rs, input bit l, input bit g, input bit pv, input logic [15:0] pd);
      reset = rs;
      bus.sensor_llegada_vehiculo = l;
      bus.sensor_ingreso_vehiculo = g;
      bus.pin_valid = pv;
      bus.pin_data  = pd;
      @(posedge clock);
      model(rs, l, g, pv, pd);
      #1;
      check_eq("estado", 32'(bus.estado), 32'(m_st));
      check_eq("cuenta_intentos", 32'(bus.cuenta_intentos), 32'(m_cnt));
      check_eq("compuerta", 32'(bus.senal_compuerta), 32'((m_st == S_OPEN) || (m_st == S_PASS)));
      check_eq("alarma_pin", 32'(bus.senal_alarma_pin), 32'(m_st == S_LOCK));
      check_eq("alarma_bloqueo", 32'(bus.senal_alarma_bloqueo), 32'(m_st == S_BLOCK));
   endtask

   int gate_cycles;
   logic [15:0] rpin;

   initial begin
      bus.sensor_llegada_vehiculo = 1'b0;
      bus.sensor_ingreso_vehiculo = 1'b0;
      bus.pin_valid = 1'b0;
      bus.pin_data  = '0;
      step(1, 0, 0, 0, 16'h0);
      step(1, 0, 0, 0, 16'h0);
      check_eq("reset_estado", 32'(bus.estado), 32'd0);

      // Arrive, correct PIN, drive through.
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h2468);
      check_eq("t1_open", 32'(bus.senal_compuerta), 32'd1);
      step(0, 0, 1, 0, 16'h0);
      check_eq("t1_passing", 32'(bus.estado), 32'd3);
      step(0, 0, 0, 0, 16'h0);
      check_eq("t1_closed", 32'(bus.senal_compuerta), 32'd0);

      // Three wrong PINs lock out; near misses must not match.
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h1111);
      check_eq("t2_cnt1", 32'(bus.cuenta_intentos), 32'd1);
      step(0, 1, 0, 1, 16'h2469);
      check_eq("t2_cnt2", 32'(bus.cuenta_intentos), 32'd2);
      step(0, 1, 0, 1, 16'hA468);
      check_eq("t2_lock", 32'(bus.senal_alarma_pin), 32'd1);
      step(0, 1, 0, 1, 16'h1111);
      step(0, 1, 0, 1, 16'h2468);
      check_eq("t2_unlock", 32'(bus.senal_alarma_pin), 32'd0);

      // Gate timeout with no entry.
      step(1, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h2468);
      gate_cycles = int'(bus.senal_compuerta);
      for (int i = 0; i < 11; i++) begin
         step(0, 1, 0, 0, 16'h0);
         gate_cycles += int'(bus.senal_compuerta);
      end
      check_eq("t3_open_len", 32'(gate_cycles), 32'(GATE_TIMEOUT));

      // Tailgating in OPEN and simultaneous with a correct PIN in WAIT_PIN.
      step(1, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h2468);
      step(0, 1, 1, 0, 16'h0);
      check_eq("t4_block_open", 32'(bus.senal_alarma_bloqueo), 32'd1);
      step(0, 1, 1, 1, 16'h2468);
      check_eq("t4_block_hold", 32'(bus.estado), 32'd5);
      step(0, 0, 0, 1, 16'h2468);
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 1, 1, 16'h2468);
      check_eq("t4_block_wait", 32'(bus.estado), 32'd5);
      step(0, 0, 0, 1, 16'h2468);
      check_eq("t4_exit", 32'(bus.estado), 32'd0);

      // Leaving clears the attempt count.
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h1111);
      step(0, 1, 0, 1, 16'h1111);
      step(0, 0, 0, 0, 16'h0);
      check_eq("t5_cleared", 32'(bus.cuenta_intentos), 32'd0);
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h1111);
      step(0, 1, 0, 1, 16'h1111);
      check_eq("t5_no_lock", 32'(bus.estado), 32'd1);

      // Reset from PIN_LOCK and from OPEN.
      step(0, 1, 0, 1, 16'h1111);
      step(1, 1, 0, 0, 16'h0);
      check_eq("t6_rst_lock", 32'(bus.estado), 32'd0);
      step(0, 1, 0, 0, 16'h0);
      step(0, 1, 0, 1, 16'h2468);
      step(1, 1, 0, 0, 16'h0);
      check_eq("t6_rst_open", 32'(bus.senal_compuerta), 32'd0);

      for (int i = 0; i < 4000; i++) begin
         case ($urandom_range(0, 3))
            0, 1:    rpin = CORRECT_PIN;
            2:       rpin = 16'h1111;
            default: rpin = 16'($urandom);
         endcase
         step($urandom_range(0, 199) == 0,
              $urandom_range(0, 9) < 6,
              $urandom_range(0, 9) < 2,
              $urandom_range(0, 9) < 3,
              rpin);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
